// File: rtl/triumph_pkg.sv
// Shared constants and the prefetch entry layout for the triumph fetch stage.
package triumph_pkg;

    localparam int unsigned INSTR_WIDTH       = 32;
    localparam logic [31:0] PC_INCR           = 32'd4;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    // One prefetched instruction travels with the PC it was fetched from.
    typedef struct packed {
        logic [31:0]            pc;
        logic [INSTR_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/triumph_fetch_fifo.sv
// Synchronous prefetch FIFO with registered head outputs that hold their last
// contents while empty; flush overrides push and pop.
module triumph_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic             do_pop;
    logic             do_push;
    logic [CW-1:0]    count_after_pop;
    logic [CW-1:0]    count_next;
    logic [PW-1:0]    rd_next;
    logic [WIDTH-1:0] head_next;

    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    assign count   = count_q;

    // The head register is loaded with whatever will sit at the front after
    // this edge; a lone entry being pushed into an emptied FIFO comes from wdata.
    always_comb begin
        count_after_pop = count_q - CW'(do_pop);
        rd_next         = rd_ptr + PW'(do_pop);
        count_next      = count_after_pop + CW'(do_push);
        head_next       = (count_after_pop == '0) ? wdata : mem[rd_next];
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            head_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr     <= rd_next;
            count_q    <= count_next;
            head_valid <= (count_next != '0);
            if (count_next != '0) begin
                head_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/triumph_fetch_unit.sv
// Instruction fetch stage: request/grant memory handshake with credit-limited
// prefetch, PC redirect and discard of stale in-flight responses.
module triumph_fetch_unit
    import triumph_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        id_ready_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_data_id_o,
    output logic [31:0] instr_pc_id_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  req_pc;
    logic [31:0]  rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credits_used;
    logic          grant;
    logic          rsp;
    logic          keep;
    logic [31:0]   branch_target;
    logic          unused_addr_bits;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Entries queued plus requests in flight may never exceed the FIFO size,
    // so every granted response is guaranteed a slot.
    assign credits_used  = {1'b0, fifo_count} + {1'b0, outstanding};
    assign instr_req_o   = !rst_i && !branch_i && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign instr_addr_o  = req_pc;
    assign grant         = instr_req_o && instr_gnt_i;
    assign rsp           = instr_rvalid_i && (outstanding != '0);
    assign keep          = rsp && (drop == '0) && !branch_i;
    assign branch_target = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_bits = ^branch_addr_i[1:0];

    assign push_entry.pc   = rsp_pc;
    assign push_entry.data = instr_rdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_pc      <= BOOT_ADDR;
            rsp_pc      <= BOOT_ADDR;
            outstanding <= '0;
            drop        <= '0;
        end else if (branch_i) begin
            // Everything still in flight belongs to the old path, except a
            // response landing right now, which is discarded on the spot.
            req_pc      <= branch_target;
            rsp_pc      <= branch_target;
            outstanding <= outstanding - CW'(rsp);
            drop        <= outstanding - CW'(rsp);
        end else begin
            if (grant) begin
                req_pc <= req_pc + PC_INCR;
            end
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (rsp) begin
                if (drop != '0) begin
                    drop <= drop - CW'(1);
                end else begin
                    rsp_pc <= rsp_pc + PC_INCR;
                end
            end
        end
    end

    triumph_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (keep),
        .wdata      (push_entry),
        .pop        (instr_valid_id_o && id_ready_i),
        .flush      (branch_i),
        .count      (fifo_count),
        .head_valid (instr_valid_id_o),
        .head_data  (head_entry)
    );

    assign instr_data_id_o = head_entry.data;
    assign instr_pc_id_o   = head_entry.pc;

endmodule

// File: tb/tb_triumph_fetch_unit.sv
// Randomized bench for triumph_fetch_unit against a queue-based model of the
// memory, the prefetch buffer and the expected fetch path.
module tb_triumph_fetch_unit;

    localparam logic [31:0] BOOT  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        rst_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        id_ready_i;
    logic        instr_valid_id_o;
    logic [31:0] instr_data_id_o;
    logic [31:0] instr_pc_id_o;

    triumph_fetch_unit #(
        .BOOT_ADDR  (BOOT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .branch_i         (branch_i),
        .branch_addr_i    (branch_addr_i),
        .id_ready_i       (id_ready_i),
        .instr_valid_id_o (instr_valid_id_o),
        .instr_data_id_o  (instr_data_id_o),
        .instr_pc_id_o    (instr_pc_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    pend_t       mem_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_req_pc;
    logic [31:0] last_pc;
    logic [31:0] last_data;
    int          cycle;
    int          max_lat;
    int          checks;
    int          errors;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
    endfunction

    function automatic bit chance(input int pct);
        return ($urandom_range(99) < pct);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cycle, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what that clock edge must do.
    task automatic applyStimulus(input bit gnt, input bit ready, input bit branch,
                                 input logic [31:0] baddr);
        bit    rv;
        bit    exp_req;
        bit    keep;
        bit    pop;
        pend_t front;
        pend_t p;
        @(negedge clk);
        rv             = (mem_q.size() > 0) && (mem_q[0].due <= cycle);
        instr_gnt_i    = gnt;
        id_ready_i     = ready;
        branch_i       = branch;
        branch_addr_i  = baddr;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? memWord(mem_q[0].addr) : $urandom;
        #1;
        exp_req = !branch && ((fifo_q.size() + mem_q.size()) < DEPTH);
        checkOutput("req", {31'b0, instr_req_o}, {31'b0, exp_req});
        checkOutput("addr", instr_addr_o, m_req_pc);
        checkOutput("valid", {31'b0, instr_valid_id_o}, {31'b0, fifo_q.size() != 0});
        if (fifo_q.size() != 0) begin
            last_pc   = fifo_q[0];
            last_data = memWord(fifo_q[0]);
        end
        checkOutput("pc", instr_pc_id_o, last_pc);
        checkOutput("data", instr_data_id_o, last_data);

        pop  = (fifo_q.size() != 0) && ready && !branch;
        keep = 1'b0;
        if (rv) begin
            front = mem_q.pop_front();
            keep  = !front.stale && !branch;
        end
        if (branch) begin
            fifo_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_req_pc = baddr & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(fifo_q.pop_front());
            if (keep) fifo_q.push_back(front.addr);
            if (exp_req && gnt) begin
                p.addr  = m_req_pc;
                p.due   = cycle + $urandom_range(max_lat, 1);
                p.stale = 1'b0;
                mem_q.push_back(p);
                m_req_pc = m_req_pc + 32'd4;
            end
        end
        @(posedge clk);
        cycle++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_i          = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        branch_i       = 1'b0;
        id_ready_i     = 1'b0;
        #1;
        checkOutput("rst_req", {31'b0, instr_req_o}, 32'd0);
        checkOutput("rst_addr", instr_addr_o, BOOT);
        checkOutput("rst_valid", {31'b0, instr_valid_id_o}, 32'd0);
        checkOutput("rst_pc", instr_pc_id_o, 32'd0);
        checkOutput("rst_data", instr_data_id_o, 32'd0);
        repeat (2) @(negedge clk);
        mem_q.delete();
        fifo_q.delete();
        m_req_pc  = BOOT;
        last_pc   = 32'd0;
        last_data = 32'd0;
        rst_i     = 1'b0;
    endtask

    task automatic runRandom(input int n, input int gnt_pct, input int ready_pct,
                             input int br_pct);
        logic [31:0] target;
        for (int i = 0; i < n; i++) begin
            target = chance(10) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
            applyStimulus(chance(gnt_pct), chance(ready_pct), chance(br_pct), target);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cycle          = 0;
        max_lat        = 1;
        rst_i          = 1'b1;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'd0;
        branch_i       = 1'b0;
        branch_addr_i  = 32'd0;
        id_ready_i     = 1'b0;
        doReset();

        $display("[TB] streaming from boot address");
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] ID backpressure");
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] redirect with requests in flight");
        max_lat = 3;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2002);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] redirect coinciding with response and pop");
        max_lat = 1;
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_4006);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] grant stall");
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] address wrap");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] reset mid-stream");
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        doReset();
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

        $display("[TB] randomized traffic");
        for (int phase = 0; phase < 8; phase++) begin
            max_lat = 1 + (phase % 4);
            runRandom(400, 40 + 8 * phase, 30 + 9 * phase, (phase % 3) * 3 + 1);
        end
        max_lat = 1;
        doReset();
        runRandom(200, 100, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
